pattern_bist_ctrl: RTL
======================

# pattern_bist_ctrl

Built-in self-test harness for the generated pattern-merge circuits: drives the circuit's primary inputs from a maximal-length LFSR and compacts its primary outputs into a MISR signature. It is the stimulus/response end of every merged pattern netlist's input/output interface. It sits beside the circuit under test and shares its clock and reset nets. The final signature is exposed, and is optionally compared on-chip against a golden value.

## Interface
Parameters:
- STIM_W, 15, stimulus width (circuit input count excluding clock/reset)
- RESP_W, 12, response width (circuit output count)
- CNT_W, 16, pattern counter width
- LFSR_SEED, 15'h0001, LFSR reload value; a zero value is replaced by 1
- DRAIN_CYC, 2, capture cycles after the last pattern, covering the circuit's register depth (≥0)

Ports:
- blif_clk_net  in  1  single clock, rising edge
- blif_reset_net  in  1  asynchronous, active-low reset
- start  in  1  launch request; honoured only in IDLE or DONE
- num_patterns  in  CNT_W  pattern count, sampled with start
- golden_sig  in  RESP_W  expected signature; ignored when comparison is compiled out
- stim  out  STIM_W  to circuit inputs
- dut_resp  in  RESP_W  from circuit outputs
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE
- signature  out  RESP_W  MISR contents
- pass  out  1  signature == golden_sig, valid while done

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN when start=1 and num_patterns≠0.
  - IDLE → DONE when start=1 and num_patterns=0; signature is cleared to 0.
  - RUN → DRAIN after num_patterns RUN cycles; goes straight to DONE if DRAIN_CYC=0.
  - DRAIN → DONE after DRAIN_CYC cycles.
  - DONE → RUN or DONE on start, with the same rules as IDLE.
- On an accepted start: LFSR ← LFSR_SEED, MISR ← 0, pattern counter ← num_patterns.
- LFSR: 15-bit Galois, right shift, polynomial x^15+x^14+1.
  - next = (lfsr>>1) ^ (lfsr[0] ? 15'h6000 : 0).
  - stim = lfsr.
  - The LFSR advances at the end of each RUN cycle except the last.
  - stim is frozen during DRAIN and DONE.
- MISR: 12-bit, polynomial x^12+x^6+x^4+x+1 (constant 12'h053).
  - next = {sig[10:0],1'b0} ^ (sig[11] ? 12'h053 : 0) ^ dut_resp.
  - Updates on every RUN and DRAIN cycle; holds in IDLE and DONE.
- start while busy: ignored; num_patterns is not resampled.
- Counter arithmetic is unsigned CNT_W with no wrap: a maximum of 2^CNT_W−1 patterns.
- Asynchronous reset at any time (including mid-run) forces IDLE and the reset values below; no partial result is kept.

## Timing
- Reset values: stim=LFSR_SEED, busy=0, done=0, signature=0, pass=0, state IDLE.
- Start accepted on edge E0: busy=1 and stim=seed from E0.
- RUN occupies cycles 1..N and DRAIN cycles N+1..N+D.
- done rises after edge E(N+D) and stays high until the next accepted start or reset.
- Start-to-done latency: N+D cycles; N=0 gives 1 cycle.
- dut_resp is sampled on the same edge that advances stim, so the circuit's combinational paths are captured in-cycle and registered paths during DRAIN.
- pass is combinational from signature and golden_sig, gated by done.

## Configuration
- PATTERN_BIST_GOLDEN_CMP_EN defined: comparator is present and pass behaves as above.
- PATTERN_BIST_GOLDEN_CMP_EN undefined: no comparator; pass is tied 0, golden_sig is unused, and the external tester reads signature.

## Structure
- Package pattern_bist_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/DONE)
  - LFSR_TAPS=15'h6000 and MISR_POLY=12'h053
  - default widths
- One sub-module, pattern_misr: parameterised MISR with clear, enable and polynomial input.
- LFSR, counter and FSM live in the top level.

## Test plan
- Reset, start=1, N=3, D=2 → stim = 0001, 6000, 3000 on RUN cycles 1–3; busy high for 5 cycles; done rises after 5 edges.
- N=1, D=2, dut_resp held at 12'h001 → signature=12'h007 when done.
- dut_resp held at 0, N=100 → signature=0; pass=1 with golden_sig=0, pass=0 with golden_sig=12'h001 (macro on); pass=0 always (macro off).
- start with N=0 → done after 1 cycle, signature=0, busy never asserted.
- Reset asserted during RUN cycle 2 → outputs immediately at reset values; a fresh start reproduces an undisturbed run.
- start pulsed during RUN → ignored and run length unchanged; start during DONE → new run with signature cleared.

Source files
------------

// File: rtl/pattern_bist_pkg.sv
// Shared types and constants for the pattern-merge BIST harness:
// controller state encoding, LFSR/MISR polynomials and default widths.
package pattern_bist_pkg;

    localparam int unsigned DEF_STIM_W = 15;
    localparam int unsigned DEF_RESP_W = 12;
    localparam int unsigned DEF_CNT_W  = 16;

    // Galois feedback for x^15+x^14+1 and MISR feedback for x^12+x^6+x^4+x+1
    localparam logic [14:0] LFSR_TAPS = 15'h6000;
    localparam logic [11:0] MISR_POLY = 12'h053;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

endpackage

// File: rtl/pattern_misr.sv
// Multiple-input signature register: left-shifting Galois compactor with
// synchronous clear, capture enable and a polynomial supplied by the parent.
module pattern_misr #(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] poly_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] sig_o
);

    logic [W-1:0] sig_q;
    logic [W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (en_i) begin
            sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? poly_i : '0) ^ data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/pattern_bist_ctrl.sv
// LFSR stimulus / MISR response harness for merged pattern netlists.
// Define PATTERN_BIST_GOLDEN_CMP_EN to build the on-chip golden comparator.
module pattern_bist_ctrl
    import pattern_bist_pkg::*;
#(
    parameter int unsigned       STIM_W    = DEF_STIM_W,
    parameter int unsigned       RESP_W    = DEF_RESP_W,
    parameter int unsigned       CNT_W     = DEF_CNT_W,
    parameter logic [STIM_W-1:0] LFSR_SEED = STIM_W'(15'h0001),
    parameter int unsigned       DRAIN_CYC = 2
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_patterns,
    input  logic [RESP_W-1:0] golden_sig,
    output logic [STIM_W-1:0] stim,
    input  logic [RESP_W-1:0] dut_resp,
    output logic              busy,
    output logic              done,
    output logic [RESP_W-1:0] signature,
    output logic              pass
);

    // An all-zero seed would lock the LFSR, so it is promoted to 1
    localparam logic [STIM_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? STIM_W'(1) : LFSR_SEED;
    localparam logic [STIM_W-1:0] TAPS     = STIM_W'(LFSR_TAPS);
    localparam logic [CNT_W-1:0]  DRAIN_LD = CNT_W'(DRAIN_CYC);

    bist_state_e       state_q, state_d;
    logic [STIM_W-1:0] lfsr_q, lfsr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              misr_clr_c;
    logic              misr_en_c;
    logic [STIM_W-1:0] lfsr_step_c;

    assign lfsr_step_c = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);

    // Next-state: the shared counter holds remaining patterns in RUN and remaining capture cycles in DRAIN
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = done_q;
        misr_clr_c = 1'b0;
        misr_en_c  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    misr_clr_c = 1'b1;
                    lfsr_d     = SEED_EFF;
                    if (num_patterns != '0) begin
                        state_d = ST_RUN;
                        cnt_d   = num_patterns;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                misr_en_c = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    if (DRAIN_CYC == 0) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                        cnt_d   = DRAIN_LD;
                    end
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    lfsr_d = lfsr_step_c;
                end
            end
            ST_DRAIN: begin
                misr_en_c = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED_EFF;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    pattern_misr #(
        .W (RESP_W)
    ) u_misr (
        .clk    (blif_clk_net),
        .rst_n  (blif_reset_net),
        .clr_i  (misr_clr_c),
        .en_i   (misr_en_c),
        .poly_i (RESP_W'(MISR_POLY)),
        .data_i (dut_resp),
        .sig_o  (signature)
    );

    assign stim = lfsr_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef PATTERN_BIST_GOLDEN_CMP_EN
    assign pass = done_q && (signature == golden_sig);
`else
    // Signature is read out by the external tester instead
    logic unused_golden;
    assign unused_golden = ^golden_sig;
    assign pass          = 1'b0;
`endif

endmodule
